// File: rtl/ir_pkg.sv
// ir_pkg: shared definitions for the IR remote transmitter.
//   - BTNx_CODE : 16-bit button codes understood by the 0x57xx receiver
//   - ir_state_e: transmitter FSM states (GAP/RPT_* used only when the
//                 IR_TX_REPEAT_EN build option is defined)
//   - *_UNITS   : state durations in timing units
//   - key_to_code(): active-low one-hot key vector -> {valid, code}
//   - is_mark() : states during which the IR envelope is high
package ir_pkg;

  localparam logic [15:0] BTN0_CODE = 16'h572F;
  localparam logic [15:0] BTN1_CODE = 16'h577F;
  localparam logic [15:0] BTN2_CODE = 16'h57BF;
  localparam logic [15:0] BTN3_CODE = 16'h573F;
  localparam logic [15:0] BTN4_CODE = 16'h57DF;
  localparam logic [15:0] BTN5_CODE = 16'h575F;
  localparam logic [15:0] BTN6_CODE = 16'h579F;
  localparam logic [15:0] BTN7_CODE = 16'h571F;
  localparam logic [15:0] BTN8_CODE = 16'h57EF;
  localparam logic [15:0] BTN9_CODE = 16'h576F;

  localparam int DUR_W = 8;
  localparam logic [DUR_W-1:0] LEAD_MARK_UNITS  = 8'd16;
  localparam logic [DUR_W-1:0] LEAD_SPACE_UNITS = 8'd8;
  localparam logic [DUR_W-1:0] RPT_SPACE_UNITS  = 8'd4;
  localparam logic [DUR_W-1:0] ONE_SPACE_UNITS  = 8'd3;
  localparam logic [DUR_W-1:0] ONE_UNIT         = 8'd1;

  typedef enum logic [3:0] {
    IDLE       = 4'd0,
    LEAD_MARK  = 4'd1,
    LEAD_SPACE = 4'd2,
    BIT_MARK   = 4'd3,
    BIT_SPACE  = 4'd4,
    STOP_MARK  = 4'd5,
    RELEASE    = 4'd6,
    GAP        = 4'd7,
    RPT_SPACE  = 4'd8,
    RPT_STOP   = 4'd9
  } ir_state_e;

  typedef struct packed {
    logic        valid;
    logic [15:0] code;
  } key_code_t;

  // Exactly one of bits 0-9 low is a button; anything else is rejected.
  function automatic key_code_t key_to_code(input logic [15:0] key_n);
    key_code_t r;
    r.valid = 1'b1;
    case (key_n)
      16'hFFFE: r.code = BTN0_CODE;
      16'hFFFD: r.code = BTN1_CODE;
      16'hFFFB: r.code = BTN2_CODE;
      16'hFFF7: r.code = BTN3_CODE;
      16'hFFEF: r.code = BTN4_CODE;
      16'hFFDF: r.code = BTN5_CODE;
      16'hFFBF: r.code = BTN6_CODE;
      16'hFF7F: r.code = BTN7_CODE;
      16'hFEFF: r.code = BTN8_CODE;
      16'hFDFF: r.code = BTN9_CODE;
      default: begin
        r.valid = 1'b0;
        r.code  = 16'h0000;
      end
    endcase
    return r;
  endfunction

  function automatic logic is_mark(input ir_state_e s);
    return (s == LEAD_MARK) || (s == BIT_MARK) || (s == STOP_MARK) || (s == RPT_STOP);
  endfunction

endpackage

// File: rtl/ir_carrier_gen.sv
// ir_carrier_gen: IR carrier square wave.
//   clk, reset_n : clock, asynchronous active-low reset
//   restart      : mark entry; forces phase high and clears the counter
//   enable       : mark in progress; carrier toggles every CARRIER_HALF cycles
//   carrier      : registered carrier, held low while not enabled
module ir_carrier_gen #(
  parameter int CARRIER_HALF = 658
) (
  input  logic clk,
  input  logic reset_n,
  input  logic restart,
  input  logic enable,
  output logic carrier
);

  localparam int CW = (CARRIER_HALF > 1) ? $clog2(CARRIER_HALF) : 1;
  localparam logic [CW-1:0] HALF_LAST = CW'(CARRIER_HALF - 1);

  logic [CW-1:0] cnt_r;
  logic          carrier_r;

  // Half-period counter and carrier phase.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_r     <= '0;
      carrier_r <= 1'b0;
    end else if (restart) begin
      cnt_r     <= '0;
      carrier_r <= 1'b1;
    end else if (enable) begin
      if (cnt_r == HALF_LAST) begin
        cnt_r     <= '0;
        carrier_r <= ~carrier_r;
      end else begin
        cnt_r <= cnt_r + CW'(1);
      end
    end else begin
      cnt_r     <= '0;
      carrier_r <= 1'b0;
    end
  end

  assign carrier = carrier_r;

endmodule

// File: rtl/ir_transmitter.sv
// ir_transmitter: NEC-style IR frame generator for the button board.
//   clk, reset_n : clock, asynchronous active-low reset
//   req          : level request, one frame per high period
//   key_n[15:0]  : active-low one-hot button vector, sampled at accept only
//   busy         : high from accept until back in IDLE
//   done         : one-cycle pulse at the end of each stop mark
//   err          : one-cycle pulse when a request carries an invalid key
//   ir_env       : unmodulated envelope (1 during marks)
//   ir_out       : LED drive, ir_env AND carrier
// Build option IR_TX_REPEAT_EN: while req stays high after a frame, wait
// GAP_UNITS units and send repeat frames (lead mark, short space, stop mark).
module ir_transmitter
  import ir_pkg::*;
#(
  parameter int UNIT_CYCLES  = 28125,
  parameter int CARRIER_HALF = 658,
  parameter int GAP_UNITS    = 71
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req,
  input  logic [15:0] key_n,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        ir_env,
  output logic        ir_out
);

  localparam int UW = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
  localparam logic [UW-1:0] UNIT_LAST = UW'(UNIT_CYCLES - 1);

  ir_state_e        state_r, state_n_s;
  logic [UW-1:0]    unit_r;
  logic [DUR_W-1:0] dur_r, len_s;
  logic [15:0]      shift_r;
  logic [3:0]       bit_r;
  logic             rpt_r;
  logic             busy_r, done_r, err_r, env_r;
  logic             busy_n_s, done_n_s, err_n_s, env_n_s;
  logic             timed_s, last_s, accept_s, carrier_s, restart_s;
  key_code_t        kc_s;

  assign kc_s     = key_to_code(key_n);
  assign accept_s = (state_r == IDLE) && req;
  assign timed_s  = (state_r != IDLE) && (state_r != RELEASE);
  assign last_s   = timed_s && (unit_r == UNIT_LAST) && (dur_r == len_s - 8'd1);

  // Duration in units of the current timed state; a data space depends on the bit.
  always_comb begin
    len_s = ONE_UNIT;
    case (state_r)
      LEAD_MARK:  len_s = LEAD_MARK_UNITS;
      LEAD_SPACE: len_s = LEAD_SPACE_UNITS;
      BIT_SPACE:  len_s = shift_r[15] ? ONE_SPACE_UNITS : ONE_UNIT;
      GAP:        len_s = DUR_W'(GAP_UNITS);
      RPT_SPACE:  len_s = RPT_SPACE_UNITS;
      default:    len_s = ONE_UNIT;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_n_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_n_s = state_r;
    case (state_r)
      IDLE: begin
        if (req) begin
          state_n_s = kc_s.valid ? LEAD_MARK : RELEASE;
        end else begin
          state_n_s = IDLE;
        end
      end
      LEAD_MARK: begin
        if (last_s) begin
          state_n_s = rpt_r ? RPT_SPACE : LEAD_SPACE;
        end else begin
          state_n_s = LEAD_MARK;
        end
      end
      LEAD_SPACE: state_n_s = last_s ? BIT_MARK : LEAD_SPACE;
      BIT_MARK:   state_n_s = last_s ? BIT_SPACE : BIT_MARK;
      BIT_SPACE: begin
        if (last_s) begin
          state_n_s = (bit_r == 4'd0) ? STOP_MARK : BIT_MARK;
        end else begin
          state_n_s = BIT_SPACE;
        end
      end
      STOP_MARK: begin
        if (last_s) begin
`ifdef IR_TX_REPEAT_EN
          state_n_s = GAP;
`else
          state_n_s = RELEASE;
`endif
        end else begin
          state_n_s = STOP_MARK;
        end
      end
      RELEASE: state_n_s = req ? RELEASE : IDLE;
`ifdef IR_TX_REPEAT_EN
      GAP: begin
        if (!req) begin
          state_n_s = IDLE;
        end else if (last_s) begin
          state_n_s = LEAD_MARK;
        end else begin
          state_n_s = GAP;
        end
      end
      RPT_SPACE: state_n_s = last_s ? RPT_STOP : RPT_SPACE;
      RPT_STOP:  state_n_s = last_s ? GAP : RPT_STOP;
`endif
      default: state_n_s = IDLE;
    endcase
  end

  // Unit/duration counters, code shift register and bit counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      unit_r  <= '0;
      dur_r   <= '0;
      shift_r <= 16'h0000;
      bit_r   <= 4'd0;
      rpt_r   <= 1'b0;
    end else begin
      // Counters restart on every state change so each state starts at unit 0.
      if (!timed_s || last_s) begin
        unit_r <= '0;
        dur_r  <= '0;
      end else if (unit_r == UNIT_LAST) begin
        unit_r <= '0;
        dur_r  <= dur_r + 8'd1;
      end else begin
        unit_r <= unit_r + UW'(1);
      end
      if (accept_s && kc_s.valid) begin
        shift_r <= kc_s.code;
        bit_r   <= 4'd15;
        rpt_r   <= 1'b0;
      end else if ((state_r == BIT_SPACE) && last_s) begin
        shift_r <= {shift_r[14:0], 1'b0};
        bit_r   <= bit_r - 4'd1;
      end else if ((state_r == GAP) && last_s) begin
        rpt_r <= 1'b1;
      end
    end
  end

  // Next values of the registered outputs.
  always_comb begin
    busy_n_s = (state_n_s != IDLE);
    env_n_s  = is_mark(state_n_s);
    done_n_s = last_s && ((state_r == STOP_MARK) || (state_r == RPT_STOP));
    err_n_s  = accept_s && !kc_s.valid;
  end

  // Output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
      err_r  <= 1'b0;
      env_r  <= 1'b0;
    end else begin
      busy_r <= busy_n_s;
      done_r <= done_n_s;
      err_r  <= err_n_s;
      env_r  <= env_n_s;
    end
  end

  // Marks never follow marks directly, so a mark entry is a space->mark step.
  assign restart_s = is_mark(state_n_s) && !is_mark(state_r);

  ir_carrier_gen #(.CARRIER_HALF(CARRIER_HALF)) u_carrier (
    .clk     (clk),
    .reset_n (reset_n),
    .restart (restart_s),
    .enable  (env_n_s),
    .carrier (carrier_s)
  );

  assign busy   = busy_r;
  assign done   = done_r;
  assign err    = err_r;
  assign ir_env = env_r;
  assign ir_out = env_r & carrier_s;

endmodule
